// File: rtl/imem_fetch_pkg.sv
// imem_fetch_pkg: shared state encoding and Sysbus constants for the instruction line fetcher.
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'h1
`endif
package imem_fetch_pkg;
    typedef enum logic [2:0] {IDLE, REQ, RESP, HOLD, DONE} state_t;
    localparam int LINE_BYTES = 64;
    localparam logic [12:0] FETCH_TAG = {1'b1, `SYSBUS_MEMORY, 8'h00};
endpackage

// File: rtl/imem_line_fetch_fifo.sv
// beat_fifo: registered-write FIFO; a push becomes visible at head on the following cycle.
module beat_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/imem_line_fetch.sv
// imem_line_fetch: PC-driven Sysbus line reader that feeds the fetch stage one 32-bit half per enabled cycle.
module imem_line_fetch
    import imem_fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH = 13,
    parameter int BEATS_PER_LINE = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    input  logic                      stall,
    output logic                      bus_reqcyc,
    output logic [63:0]               bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic                      bus_respack,
    output logic                      fetch_en,
    output logic [BUS_DATA_WIDTH-1:0] data,
    output logic                      end_of_cycle
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t state;
    logic [63:0] pc;
    logic [2:0] skip, beat_cnt;
    logic half, done, eoc, hit, done_nxt, push, pop, empty, full, last_beat, room;
    logic [BUS_DATA_WIDTH-1:0] head, data_q;
    logic [CW-1:0] count, cnt_nxt;
    logic [31:0] word;
    logic unused_ok;

    beat_fifo #(.WIDTH(BUS_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .wdata(bus_resp),
        .head(head),
        .full(full),
        .empty(empty),
        .count(count)
    );

    assign unused_ok = ^{entry[2:0], full};
    assign fetch_en = !empty && !stall && !done;
    assign word = half ? head[63:32] : head[31:0];
    assign hit = fetch_en && word == 32'h0;
    assign done_nxt = done || hit;
    assign pop = fetch_en && half;
    assign push = state == RESP && bus_respcyc && beat_cnt >= skip;
    assign last_beat = beat_cnt == 3'(BEATS_PER_LINE - 1);
    // Occupancy after this cycle's write and pop decides whether another full line fits.
    assign cnt_nxt = count + CW'(push) - CW'(pop);
    assign room = cnt_nxt <= CW'(FIFO_DEPTH - BEATS_PER_LINE);
    assign bus_reqcyc = state == REQ;
    assign bus_req = pc;
    assign bus_reqtag = BUS_TAG_WIDTH'(FETCH_TAG);
    assign bus_respack = bus_respcyc && (state == RESP || state == DONE);
    assign data = fetch_en ? head : data_q;
    assign end_of_cycle = eoc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc <= '0;
            skip <= '0;
            beat_cnt <= '0;
            half <= 1'b0;
            done <= 1'b0;
            eoc <= 1'b0;
            data_q <= '0;
        end else begin
            eoc <= hit;
            done <= done_nxt;
            data_q <= data;
            if (fetch_en) half <= !half;
            case (state)
                IDLE: begin
                    pc <= {entry[63:6], 6'b0};
                    skip <= entry[5:3];
                    state <= REQ;
                end
                REQ: begin
                    // Once the terminating word is seen no further line is wanted.
                    if (done_nxt) state <= DONE;
                    else if (bus_reqack) begin
                        state <= RESP;
                        beat_cnt <= '0;
                    end
                end
                RESP: begin
                    if (bus_respcyc) begin
                        beat_cnt <= beat_cnt + 3'd1;
                        if (last_beat) begin
                            pc <= pc + 64'(LINE_BYTES);
                            skip <= '0;
                            state <= done_nxt ? DONE : room ? REQ : HOLD;
                        end
                    end
                end
                HOLD: state <= done_nxt ? DONE : room ? REQ : HOLD;
                default: state <= DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_line_fetch.sv
// tb_imem_line_fetch: scoreboard bench driving Sysbus line reads and checking the issued word stream.
module tb_imem_line_fetch;
    import imem_fetch_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;
    logic bus_reqack = 1'b0;
    logic bus_respcyc = 1'b0;
    logic [63:0] entry = '0;
    logic [63:0] bus_resp = '0;
    logic bus_reqcyc, bus_respack, fetch_en, end_of_cycle;
    logic [63:0] bus_req, data;
    logic [12:0] bus_reqtag;

    always #5 clk = ~clk;

    imem_line_fetch dut (
        .clk(clk),
        .reset(reset),
        .entry(entry),
        .stall(stall),
        .bus_reqcyc(bus_reqcyc),
        .bus_req(bus_req),
        .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp),
        .bus_respack(bus_respack),
        .fetch_en(fetch_en),
        .data(data),
        .end_of_cycle(end_of_cycle)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    bit mon_on = 0;
    bit m_half = 0;
    bit m_done = 0;
    bit exp_eoc = 0;
    int n_fetched = 0;
    logic [31:0] m_w, m_e;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops the expected word for every fetch_en cycle and tracks the terminating pulse.
    always @(negedge clk) begin
        if (!mon_on) begin
            m_half = 0;
            m_done = 0;
            exp_eoc = 0;
        end else begin
            check("end_of_cycle", end_of_cycle, exp_eoc);
            exp_eoc = 0;
            if (fetch_en) begin
                if (m_done || exp_q.size() == 0) check("unexpected fetch_en", fetch_en, 0);
                else begin
                    m_w = m_half ? data[63:32] : data[31:0];
                    m_e = exp_q.pop_front();
                    check("fetch word", m_w, m_e);
                    n_fetched++;
                    if (m_e == 32'h0) begin
                        m_done = 1;
                        exp_eoc = 1;
                    end
                end
                m_half = !m_half;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] e);
        mon_on = 0;
        reset = 1;
        entry = e;
        tick();
        bus_respcyc = 0;
        bus_reqack = 0;
        stall = 0;
        exp_q.delete();
        @(negedge clk);
        check("reset bus_reqcyc", bus_reqcyc, 0);
        check("reset bus_respack", bus_respack, 0);
        check("reset fetch_en", fetch_en, 0);
        check("reset end_of_cycle", end_of_cycle, 0);
        check("reset data", data, 0);
        check("reset bus_req", bus_req, 0);
        tick();
        reset = 0;
        mon_on = 1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus_reqcyc) break;
        end
        check("bus_reqcyc wait", bus_reqcyc, 1);
    endtask

    task automatic ack();
        bus_reqack = 1;
        tick();
        bus_reqack = 0;
    endtask

    task automatic send_beat(input logic [63:0] v);
        bus_resp = v;
        bus_respcyc = 1;
        @(negedge clk);
        check("bus_respack", bus_respack, 1);
        tick();
        bus_respcyc = 0;
    endtask

    // Beat k of a line carries low=base+2k+1, high=base+2k+2; beat zk gets a zero high word.
    task automatic burst(input int base, input int skip, input int zk);
        logic [63:0] v;
        bit cut;
        cut = 0;
        for (int k = 0; k < 8; k++) begin
            v = {32'(base + 2*k + 2), 32'(base + 2*k + 1)};
            if (k == zk) v[63:32] = '0;
            if (k >= skip && !cut) begin
                exp_q.push_back(v[31:0]);
                exp_q.push_back(v[63:32]);
                cut = (k == zk);
            end
            send_beat(v);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("scoreboard drained", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [63:0] entry;
        int ack_delay;
        logic [63:0] exp_req;
        logic [63:0] exp_next;
        int skip;
    } vec_t;
    vec_t vecs[3];
    int n0;

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{64'h1000, 3, 64'h1000, 64'h1040, 0};
        vecs[1] = '{64'h1018, 0, 64'h1000, 64'h1040, 3};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFE5, 1, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0, 4};
        foreach (vecs[i]) begin
            do_reset(vecs[i].entry);
            @(negedge clk);
            check("bus_reqcyc in IDLE", bus_reqcyc, 0);
            @(negedge clk);
            check("bus_reqcyc after IDLE", bus_reqcyc, 1);
            check("bus_req", bus_req, vecs[i].exp_req);
            check("bus_reqtag", bus_reqtag, 13'h1100);
            repeat (vecs[i].ack_delay) begin
                @(negedge clk);
                check("bus_reqcyc held", bus_reqcyc, 1);
                check("bus_req held", bus_req, vecs[i].exp_req);
            end
            ack();
            burst(0, vecs[i].skip, -1);
            drain();
            wait_req();
            check("next bus_req", bus_req, vecs[i].exp_next);
        end

        // Stall between low and high half of the first beat.
        do_reset(64'h1000);
        stall = 1;
        wait_req();
        ack();
        burst(100, 0, -1);
        n0 = n_fetched;
        stall = 0;
        tick();
        stall = 1;
        repeat (5) begin
            @(negedge clk);
            check("fetch_en under stall", fetch_en, 0);
        end
        check("words through stall window", n_fetched - n0, 1);
        tick();
        stall = 0;
        drain();

        // Nine buffered beats force HOLD until one beat is popped.
        do_reset(64'h1038);
        stall = 1;
        wait_req();
        ack();
        burst(200, 7, -1);
        wait_req();
        check("second line bus_req", bus_req, 64'h1040);
        ack();
        burst(300, 0, -1);
        repeat (4) begin
            @(negedge clk);
            check("no request in HOLD", bus_reqcyc, 0);
        end
        tick();
        stall = 0;
        @(negedge clk);
        check("HOLD after low half", bus_reqcyc, 0);
        @(negedge clk);
        check("HOLD during popping half", bus_reqcyc, 0);
        tick();
        stall = 1;
        @(negedge clk);
        check("request after pop", bus_reqcyc, 1);
        check("third line bus_req", bus_req, 64'h1080);
        stall = 0;
        drain();

        // Zero high word in beat 5 terminates fetching.
        do_reset(64'h2000);
        wait_req();
        ack();
        burst(400, 0, 5);
        for (int i = 0; i < 100 && !m_done; i++) @(negedge clk);
        check("zero word reached", m_done, 1);
        check("no words left", exp_q.size(), 0);
        repeat (20) begin
            @(negedge clk);
            check("no request after end", bus_reqcyc, 0);
        end
        tick();
        bus_resp = 64'hDEAD_BEEF_0000_0001;
        bus_respcyc = 1;
        @(negedge clk);
        check("DONE acks stray beat", bus_respack, 1);
        tick();
        bus_respcyc = 0;
        repeat (4) @(negedge clk);

        // Reset in the middle of a burst.
        do_reset(64'h3000);
        stall = 1;
        wait_req();
        ack();
        for (int k = 0; k < 4; k++) send_beat({32'(2*k + 2), 32'(2*k + 1)});
        bus_resp = 64'h0000_000A_0000_0009;
        bus_respcyc = 1;
        do_reset(64'h5010);
        wait_req();
        check("request after mid-burst reset", bus_req, 64'h5000);
        repeat (3) begin
            @(negedge clk);
            check("FIFO empty after reset", fetch_en, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
